// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges per-stage stall requests, redirects on MEM-stage
// exceptions/ERET (deferring while an IF bus transfer is in flight) and keeps perf counters.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        perf_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        ctrl_busy,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {StRun, StWaitBus} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pend_pc;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  logic        w_has_exc;
  logic        w_defer;
  logic [31:0] w_tgt;

  assign w_has_exc = (excepttype_i != '0);
  assign w_tgt     = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
  // An exception arriving while a fetch is outstanding must wait for the bus to drain.
  assign w_defer   = (r_state == StRun) && w_has_exc && stallreq_from_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StRun;
      r_pend_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_defer) begin
        r_pend_pc <= w_tgt;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:     if (w_defer) w_state_next = StWaitBus;
      StWaitBus: if (!stallreq_from_if) w_state_next = StRun;
    endcase
  end

  always_comb begin
    stall     = '0;
    flush     = 1'b0;
    new_pc    = '0;
    ctrl_busy = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StRun: begin
          if (w_has_exc && !stallreq_from_if) begin
            flush  = 1'b1;
            new_pc = w_tgt;
          end else if (w_has_exc) begin
            stall = 6'b111111;
          end else if (stallreq_from_mem) begin
            stall = 6'b011111;
          end else if (stallreq_from_ex) begin
            stall = 6'b001111;
          end else if (stallreq_from_id) begin
            stall = 6'b000111;
          end else if (stallreq_from_if) begin
            stall = 6'b000011;
          end
        end
        StWaitBus: begin
          ctrl_busy = 1'b1;
          if (stallreq_from_if) begin
            stall = 6'b111111;
          end else begin
            flush  = 1'b1;
            new_pc = r_pend_pc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((stall != '0) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: an abstract reference model checked every cycle plus
// hand-computed literal expectations at the interesting points.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
  logic [31:0] exc = '0, epc = '0;
  logic        perf_clr = 1'b0;
  logic [5:0]  stall;
  logic        flush, ctrl_busy;
  logic [31:0] new_pc, stall_cycles;
  logic [15:0] flush_count;

  int checks = 0;
  int failures = 0;

  pipeline_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .perf_clr          (perf_clr),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .ctrl_busy         (ctrl_busy),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "waiting" flag, the remembered target and plain counters.
  logic        m_wait = 1'b0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_stall_cnt = '0;
  logic [15:0] m_flush_cnt = '0;
  logic        m_stall_cnt_valid = 1'b1;

  task automatic model_out(output logic [5:0] e_stall, output logic e_flush,
                           output logic [31:0] e_pc, output logic e_busy);
    int stopped;
    logic [31:0] tgt;
    e_stall = '0; e_flush = 1'b0; e_pc = '0; e_busy = 1'b0;
    tgt = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
    if (rst) return;
    if (m_wait) begin
      e_busy = 1'b1;
      if (req_if) e_stall = 6'h3f;
      else begin e_flush = 1'b1; e_pc = m_pend; end
    end else if (exc != 0) begin
      if (!req_if) begin e_flush = 1'b1; e_pc = tgt; end
      else e_stall = 6'h3f;
    end else begin
      // Number of stopped stages counted from the PC end.
      stopped = req_mem ? 5 : req_ex ? 4 : req_id ? 3 : req_if ? 2 : 0;
      e_stall = 6'((1 << stopped) - 1);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_busy;
    logic [31:0] e_pc;
    model_out(e_stall, e_flush, e_pc, e_busy);
    chk("model_stall", 32'(stall), 32'(e_stall));
    chk("model_flush", 32'(flush), 32'(e_flush));
    chk("model_new_pc", new_pc, e_pc);
    chk("model_busy", 32'(ctrl_busy), 32'(e_busy));
    chk("model_flush_count", 32'(flush_count), 32'(m_flush_cnt));
    if (m_stall_cnt_valid) chk("model_stall_cycles", stall_cycles, m_stall_cnt);
  end

  always @(posedge clk or posedge rst) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_busy;
    logic [31:0] e_pc;
    if (rst) begin
      m_wait = 1'b0; m_pend = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      model_out(e_stall, e_flush, e_pc, e_busy);
      if (m_wait) begin
        if (!req_if) m_wait = 1'b0;
      end else if (exc != 0 && req_if) begin
        m_wait = 1'b1;
        m_pend = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
      end
      if (perf_clr) begin
        m_stall_cnt = '0; m_flush_cnt = '0;
      end else begin
        if (e_stall != 0 && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
        if (e_flush && m_flush_cnt != 16'hFFFF) m_flush_cnt = m_flush_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic f_if, input logic f_id, input logic f_ex, input logic f_mem,
                     input logic [31:0] f_exc, input logic [31:0] f_epc);
    req_if = f_if; req_id = f_id; req_ex = f_ex; req_mem = f_mem; exc = f_exc; epc = f_epc;
    #1;
  endtask

  initial begin
    step();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    chk("reset_flush_count", 32'(flush_count), 32'd0);

    // Reset asserted mid-cycle forces outputs immediately and drops the flush.
    step();
    drv(0, 0, 1, 0, 32'd1, 0);
    chk("exc_beats_ex_flush", 32'(flush), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    step();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("rst_release_flush_count", 32'(flush_count), 32'd0);
    chk("rst_release_stall_cycles", stall_cycles, 32'd0);

    step();
    drv(0, 1, 0, 0, 0, 0);
    chk("id_stall", 32'(stall), 32'h07);
    step(); step(); step();
    drv(0, 1, 1, 0, 0, 0);
    chk("ex_id_stall", 32'(stall), 32'h0f);
    step(); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("stall_cycles_5", stall_cycles, 32'd5);

    step();
    drv(0, 0, 0, 0, 32'd1, 32'h1234_5678);
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_new_pc", new_pc, 32'h0000_0020);
    chk("exc_stall", 32'(stall), 32'd0);
    step();
    drv(0, 0, 0, 0, 32'h0000_000e, 32'h8000_1234);
    chk("flush_count_1", 32'(flush_count), 32'd1);
    chk("eret_new_pc", new_pc, 32'h8000_1234);
    step();
    drv(0, 0, 0, 0, 32'd3, 0);
    step();
    drv(0, 0, 0, 0, 32'd3, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("flush_count_back_to_back", 32'(flush_count), 32'd4);
    chk("no_flush_pc_zero", new_pc, 32'd0);

    step(); drv(1, 1, 1, 1, 0, 0);
    chk("all_req_stall", 32'(stall), 32'h1f);
    step(); drv(1, 0, 0, 0, 0, 0);
    chk("if_only_stall", 32'(stall), 32'h03);
    step(); drv(0, 0, 0, 1, 32'd2, 0);
    chk("exc_beats_mem_stall", 32'(stall), 32'd0);
    chk("exc_beats_mem_flush", 32'(flush), 32'd1);

    // Deferred redirect: the target is latched on entry, later EPC changes are ignored.
    step(); drv(1, 0, 0, 0, 32'd1, 32'h0000_1111);
    chk("defer_entry_stall", 32'(stall), 32'h3f);
    chk("defer_entry_flush", 32'(flush), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); drv(1, 0, 0, 0, 32'd1, 32'hCAFE_0000 + 32'(i));
      chk("wait_busy", 32'(ctrl_busy), 32'd1);
      chk("wait_stall", 32'(stall), 32'h3f);
    end
    step(); drv(0, 0, 0, 0, 32'd1, 32'hDEAD_BEEF);
    chk("defer_flush", 32'(flush), 32'd1);
    chk("defer_new_pc", new_pc, 32'h0000_0020);
    step(); drv(0, 0, 0, 0, 0, 0);
    chk("defer_back_run", 32'(ctrl_busy), 32'd0);
    chk("flush_count_6", 32'(flush_count), 32'd6);

    step(); drv(1, 0, 0, 0, 32'h0000_000e, 32'h0000_4000);
    step(); drv(0, 0, 0, 0, 32'h0000_000e, 32'h0000_5000);
    chk("min_latency_flush", 32'(flush), 32'd1);
    chk("min_latency_pc", new_pc, 32'h0000_4000);
    step(); drv(0, 0, 0, 0, 0, 0);

    // Saturation: preload the stall counter close to its maximum.
    step();
    drv(0, 0, 0, 1, 0, 0);
    m_stall_cnt_valid = 1'b0;
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    step();
    release dut.r_stall_cycles;
    repeat (4) step();
    m_stall_cnt = 32'hFFFF_FFFF;
    m_stall_cnt_valid = 1'b1;
    chk("stall_cycles_saturated", stall_cycles, 32'hFFFF_FFFF);
    step();
    chk("stall_cycles_hold", stall_cycles, 32'hFFFF_FFFF);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("perf_clr_stall_cycles", stall_cycles, 32'd0);
    chk("perf_clr_flush_count", 32'(flush_count), 32'd0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush controller that drives the `stall[5:0]` and `flush` inputs consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Merges per-stage stall requests and handles exception/ERET redirects from the MEM stage, producing `new_pc`.
- Defers a redirect while an instruction-fetch bus transaction is still in flight, so the fetch is never aborted mid-transfer.
- Keeps saturating performance counters for stall cycles and flushes.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect target for every exception other than ERET.
- ERET_CODE, 32'h0000000e, `excepttype_i` value meaning ERET (redirect to `cp0_epc_i`).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stallreq_from_if  input  1  IF bus transaction outstanding.
- stallreq_from_id  input  1  load-use hazard in ID.
- stallreq_from_ex  input  1  multi-cycle EX op (div/madd) busy.
- stallreq_from_mem  input  1  data bus transaction outstanding.
- excepttype_i  input  32  exception code from MEM stage; 0 = none.
- cp0_epc_i  input  32  current CP0 EPC.
- perf_clr  input  1  synchronous clear of perf counters.
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- flush  output  1  flush all pipeline registers this cycle.
- new_pc  output  32  redirect PC, valid when `flush`=1.
- ctrl_busy  output  1  redirect pending, state = WAIT_BUS.
- stall_cycles  output  32  cycles with `stall` != 0, saturating.
- flush_count  output  16  flush pulses issued, saturating.

Behaviour:
- Reset:
  - Asynchronous, active-high; state = RUN, `pend_pc` = 0, both counters = 0.
  - While `rst`=1, outputs are forced: `stall` = 6'b000000, `flush` = 0, `new_pc` = 0, `ctrl_busy` = 0.
  - Reset mid-WAIT_BUS abandons the pending redirect without issuing a flush.
- `stall`, `flush`, `new_pc` are combinational from the current state and inputs, so pipeline registers act on them at the same clock edge.
- Redirect target: `tgt` = `cp0_epc_i` if `excepttype_i` == ERET_CODE, else EXC_VECTOR.
- State RUN, evaluated in priority order:
  1. `excepttype_i` != 0 and `stallreq_from_if` = 0: `flush` = 1, `new_pc` = `tgt`, `stall` = 0. Stay in RUN.
  2. `excepttype_i` != 0 and `stallreq_from_if` = 1: `flush` = 0, `stall` = 6'b111111. Latch `pend_pc` <= `tgt`; next state WAIT_BUS.
  3. Otherwise `flush` = 0 and `stall` follows the first active request:
     - `stallreq_from_mem`: 6'b011111
     - `stallreq_from_ex`: 6'b001111
     - `stallreq_from_id`: 6'b000111
     - `stallreq_from_if`: 6'b000011
     - none: 6'b000000
- State WAIT_BUS (`ctrl_busy` = 1):
  - `excepttype_i` and `cp0_epc_i` are ignored; the frozen pipeline holds them anyway.
  - While `stallreq_from_if` = 1: `stall` = 6'b111111, `flush` = 0.
  - First cycle `stallreq_from_if` = 0: `flush` = 1, `new_pc` = `pend_pc`, `stall` = 0; next state RUN.
  - Minimum deferred-flush latency: 1 cycle after entry.
- Exactly one flush cycle per exception event. The MEM stage clears `excepttype_i` after the flush; a value still nonzero on the following cycle counts as a new event.
- `new_pc` = 0 whenever `flush` = 0.
- Counters, updated at each clock edge:
  - `perf_clr` = 1 zeroes both counters and has priority over increment.
  - `stall_cycles` increments when `stall` != 0 and saturates at 32'hFFFFFFFF.
  - `flush_count` increments when `flush` = 1 and saturates at 16'hFFFF.
- Simultaneous stall requests are resolved by the priority list above. Exception always beats stall requests in RUN.

Test Plan:
- Reset pulse mid-cycle with `stallreq_from_ex`=1 and `excepttype_i`=1 -> `stall`=0, `flush`=0, `new_pc`=0 immediately; counters read 0 after release.
- `stallreq_from_id`=1 for 3 cycles, then `stallreq_from_ex`=1 together with `stallreq_from_id`=1 for 2 cycles -> `stall`=000111 ×3, then 001111 ×2; `stall_cycles`=5.
- `excepttype_i`=32'h00000001, no IF stall -> same cycle `flush`=1, `new_pc`=32'h00000020, `stall`=0; `flush_count`=1.
- `excepttype_i`=32'h0000000e, `cp0_epc_i`=32'h80001234, no IF stall -> `flush`=1, `new_pc`=32'h80001234.
- `excepttype_i`=1 with `stallreq_from_if`=1 for 4 cycles; change `cp0_epc_i` during the wait -> `stall`=111111 and `ctrl_busy`=1 for 4 cycles, then a single `flush` with `new_pc`=32'h00000020; back to RUN.
- Preload `stall_cycles` near saturation (force, or long `stallreq_from_mem`); assert `perf_clr` together with an active stall -> counter = 0 next cycle; saturation holds at 32'hFFFFFFFF.
